// File: rtl/mem_copy_engine.sv
// Simple DMA block-copy engine for the single-port 8-bit data memory.
// Each byte is moved with one read cycle followed by one write cycle, in ascending address order.
module mem_copy_engine (
  input  logic       CLK,
  input  logic       reset,
  input  logic       Start,
  input  logic [7:0] SrcAddr,
  input  logic [7:0] DstAddr,
  input  logic [7:0] Length,
  input  logic [7:0] MemRdData,
  output logic [7:0] DataAddress,
  output logic       ReadMem,
  output logic       WriteMem,
  output logic [7:0] MemWrData,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Remaining
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q;
  logic [7:0] src_q;
  logic [7:0] dst_q;
  logic [7:0] cnt_q;
  logic [7:0] hold_q;

  // Operands are latched only from IDLE, so a Start seen mid-transfer cannot disturb them.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= 8'd0;
      dst_q   <= 8'd0;
      cnt_q   <= 8'd0;
      hold_q  <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            src_q   <= SrcAddr;
            dst_q   <= DstAddr;
            cnt_q   <= Length;
            state_q <= (Length != 8'd0) ? S_READ : S_DONE;
          end
        end
        S_READ: begin
          hold_q  <= MemRdData;
          src_q   <= src_q + 8'd1;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          dst_q   <= dst_q + 8'd1;
          cnt_q   <= cnt_q - 8'd1;
          state_q <= (cnt_q == 8'd1) ? S_DONE : S_READ;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Moore decode: outputs depend only on registers, so reset clears them without a clock edge.
  always_comb begin
    DataAddress = 8'd0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    Remaining   = 8'd0;
    case (state_q)
      S_READ: begin
        DataAddress = src_q;
        ReadMem     = 1'b1;
        Busy        = 1'b1;
        Remaining   = cnt_q;
      end
      S_WRITE: begin
        DataAddress = dst_q;
        WriteMem    = 1'b1;
        Busy        = 1'b1;
        Remaining   = cnt_q;
      end
      S_DONE: begin
        Done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign MemWrData = hold_q;

endmodule
